gpu_instruction_buffer: RTL and testbench

GPU_INSTRUCTION_BUFFER -- requirements
Module: gpu_instruction_buffer

---
 rtl/gpu_instruction_buffer_if.sv | 30 +++
 rtl/gpu_instruction_buffer.sv | 209 ++++++++++++++++++++
 tb/tb_gpu_instruction_buffer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_instruction_buffer_if.sv
// Head-of-queue draw instruction channel between the instruction buffer
// and the rasterizer. The buffer drives the instruction fields and valid_o.
// The rasterizer returns ready_i.
interface gpu_instruction_buffer_if #(
   parameter int WIDTH_BITS   = 10,
   parameter int HEIGHT_BITS  = 9,
   parameter int CHANNEL_BITS = 8
);
   logic [3:0]              op_o;
   logic [WIDTH_BITS-1:0]   x1_o;
   logic [HEIGHT_BITS-1:0]  y1_o;
   logic [WIDTH_BITS-1:0]   x2_o;
   logic [HEIGHT_BITS-1:0]  y2_o;
   logic [WIDTH_BITS-1:0]   rad_o;
   logic [CHANNEL_BITS-1:0] r_o;
   logic [CHANNEL_BITS-1:0] g_o;
   logic [CHANNEL_BITS-1:0] b_o;
   logic                    valid_o;
   logic                    ready_i;

   modport master (
      output op_o, x1_o, y1_o, x2_o, y2_o, rad_o, r_o, g_o, b_o, valid_o,
      input  ready_i
   );

   modport slave (
      input  op_o, x1_o, y1_o, x2_o, y2_o, rad_o, r_o, g_o, b_o, valid_o,
      output ready_i
   );
endinterface

// File: rtl/gpu_instruction_buffer.sv
// GPU draw-instruction buffer. Decoded operand writes are collected in
// staging registers. Line and rect pushes snapshot the staging registers
// together with the colour into a first-word-fall-through queue. The
// rasterizer drains that queue through the draw channel. A command with
// opcode 0000 is a soft clear: it empties the queue, zeroes the staging
// registers and clears the sticky overflow flag.
module gpu_instruction_buffer #(
   parameter int FIFO_DEPTH   = 4,
   parameter int WIDTH_BITS   = 10,
   parameter int HEIGHT_BITS  = 9,
   parameter int CHANNEL_BITS = 8
) (
   input  logic                            clk_i,
   input  logic                            n_rst_i,
   input  logic                            command_i,
   input  logic [3:0]                      opcode_i,
   input  logic [WIDTH_BITS-1:0]           x1_i,
   input  logic [HEIGHT_BITS-1:0]          y1_i,
   input  logic [WIDTH_BITS-1:0]           x2_i,
   input  logic [HEIGHT_BITS-1:0]          y2_i,
   input  logic [WIDTH_BITS-1:0]           rad_i,
   input  logic [CHANNEL_BITS-1:0]         r_i,
   input  logic [CHANNEL_BITS-1:0]         g_i,
   input  logic [CHANNEL_BITS-1:0]         b_i,
   input  logic                            write_enable_i,
   input  logic                            push_instruction_i,
   output logic                            full_o,
   output logic                            empty_o,
   output logic [$clog2(FIFO_DEPTH):0]     count_o,
   output logic                            overflow_o,
   gpu_instruction_buffer_if.master        draw_if
);

   localparam int PTR_BITS = $clog2(FIFO_DEPTH);
   localparam int CNT_BITS = PTR_BITS + 1;

   localparam logic [3:0] OP_CLEAR = 4'b0000;
   localparam logic [3:0] OP_XY1   = 4'b0001;
   localparam logic [3:0] OP_XY2   = 4'b0010;
   localparam logic [3:0] OP_RAD   = 4'b0011;
   localparam logic [3:0] OP_LINE  = 4'b0100;
   localparam logic [3:0] OP_RECT  = 4'b0101;

   localparam logic [PTR_BITS-1:0] PTR_ONE   = PTR_BITS'(1);
   localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0] CNT_ZERO  = CNT_BITS'(0);
   localparam logic [CNT_BITS-1:0] CNT_DEPTH = CNT_BITS'(FIFO_DEPTH);

   typedef struct packed {
      logic [3:0]              op;
      logic [WIDTH_BITS-1:0]   x1;
      logic [HEIGHT_BITS-1:0]  y1;
      logic [WIDTH_BITS-1:0]   x2;
      logic [HEIGHT_BITS-1:0]  y2;
      logic [WIDTH_BITS-1:0]   rad;
      logic [CHANNEL_BITS-1:0] r;
      logic [CHANNEL_BITS-1:0] g;
      logic [CHANNEL_BITS-1:0] b;
   } entry_t;

   // staging registers
   logic [WIDTH_BITS-1:0]  x1_r;
   logic [HEIGHT_BITS-1:0] y1_r;
   logic [WIDTH_BITS-1:0]  x2_r;
   logic [HEIGHT_BITS-1:0] y2_r;
   logic [WIDTH_BITS-1:0]  rad_r;

   // queue state
   entry_t                 mem_r [FIFO_DEPTH];
   logic [PTR_BITS-1:0]    wr_ptr_r;
   logic [PTR_BITS-1:0]    rd_ptr_r;
   logic [CNT_BITS-1:0]    count_r;
   logic                   full_r;
   logic                   empty_r;
   logic                   overflow_r;

   // decoded controls
   logic                   srst_s;
   logic                   push_req_s;
   logic                   push_s;
   logic                   pop_s;
   logic                   drop_s;
   logic [CNT_BITS-1:0]    count_nxt_s;
   entry_t                 push_entry_s;
   entry_t                 head_s;

   // Decode strobes into push/pop/drop decisions and the next occupancy.
   always_comb begin
      srst_s       = command_i && (opcode_i == OP_CLEAR);
      push_req_s   = push_instruction_i && ((opcode_i == OP_LINE) || (opcode_i == OP_RECT));
      pop_s        = !empty_r && draw_if.ready_i;
      push_s       = push_req_s && (!full_r || pop_s);
      drop_s       = push_req_s && full_r && !pop_s;
      count_nxt_s  = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
      push_entry_s = '{op: opcode_i, x1: x1_r, y1: y1_r, x2: x2_r, y2: y2_r,
                       rad: rad_r, r: r_i, g: g_i, b: b_i};
   end

   // Staging registers: operand writes by opcode, zeroed by reset or soft clear.
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         x1_r  <= '0;
         y1_r  <= '0;
         x2_r  <= '0;
         y2_r  <= '0;
         rad_r <= '0;
      end else if (srst_s) begin
         x1_r  <= '0;
         y1_r  <= '0;
         x2_r  <= '0;
         y2_r  <= '0;
         rad_r <= '0;
      end else if (write_enable_i) begin
         case (opcode_i)
            OP_XY1: begin
               x1_r <= x1_i;
               y1_r <= y1_i;
            end
            OP_XY2: begin
               x2_r <= x2_i;
               y2_r <= y2_i;
            end
            OP_RAD:  rad_r <= rad_i;
            default: begin
            end
         endcase
      end
   end

   // Queue storage: accepted pushes are written at the write pointer.
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (push_s && !srst_s) begin
         mem_r[wr_ptr_r] <= push_entry_s;
      end
   end

   // Queue control: pointers, occupancy, status flags and the sticky overflow.
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= CNT_ZERO;
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         overflow_r <= 1'b0;
      end else if (srst_s) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= CNT_ZERO;
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         overflow_r <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == CNT_DEPTH);
         empty_r <= (count_nxt_s == CNT_ZERO);
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         if (drop_s) begin
            overflow_r <= 1'b1;
         end else begin
            overflow_r <= overflow_r;
         end
      end
   end

   // Head entry straight from storage, forced to zero while the queue is empty.
   always_comb begin
      if (empty_r) begin
         head_s = '0;
      end else begin
         head_s = mem_r[rd_ptr_r];
      end
   end

   assign draw_if.op_o    = head_s.op;
   assign draw_if.x1_o    = head_s.x1;
   assign draw_if.y1_o    = head_s.y1;
   assign draw_if.x2_o    = head_s.x2;
   assign draw_if.y2_o    = head_s.y2;
   assign draw_if.rad_o   = head_s.rad;
   assign draw_if.r_o     = head_s.r;
   assign draw_if.g_o     = head_s.g;
   assign draw_if.b_o     = head_s.b;
   assign draw_if.valid_o = !empty_r;

   assign full_o     = full_r;
   assign empty_o    = empty_r;
   assign count_o    = count_r;
   assign overflow_o = overflow_r;

endmodule

// File: tb/tb_gpu_instruction_buffer.sv
// Scoreboard bench for gpu_instruction_buffer. The stimulus side pushes each
// accepted instruction into an expected queue. A negedge monitor compares
// the presented head entry against the queue front, and pops the front when
// the rasterizer side accepts it.
module tb_gpu_instruction_buffer;

   localparam int DEPTH = 4;
   localparam int WB    = 10;
   localparam int HB    = 9;
   localparam int CB    = 8;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int EW    = 4 + 3 * WB + 2 * HB + 3 * CB;

   logic          clk = 1'b0;
   logic          n_rst = 1'b1;
   logic          command;
   logic [3:0]    opcode;
   logic [WB-1:0] x1, x2, rad;
   logic [HB-1:0] y1, y2;
   logic [CB-1:0] r, g, b;
   logic          write_enable;
   logic          push_instruction;
   logic          full, empty, overflow;
   logic [CW-1:0] count;

   int pass_cnt  = 0;
   int check_cnt = 0;

   logic [EW-1:0] exp_q [$];
   logic [WB-1:0] sx1, sx2, srad;
   logic [HB-1:0] sy1, sy2;
   bit            ovf_m;
   logic [EW-1:0] head_v;

   always #5 clk = ~clk;

   gpu_instruction_buffer_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .CHANNEL_BITS(CB)) draw_if ();

   gpu_instruction_buffer #(
      .FIFO_DEPTH(DEPTH), .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .CHANNEL_BITS(CB)
   ) dut (
      .clk_i(clk), .n_rst_i(n_rst), .command_i(command), .opcode_i(opcode),
      .x1_i(x1), .y1_i(y1), .x2_i(x2), .y2_i(y2), .rad_i(rad),
      .r_i(r), .g_i(g), .b_i(b),
      .write_enable_i(write_enable), .push_instruction_i(push_instruction),
      .full_o(full), .empty_o(empty), .count_o(count), .overflow_o(overflow),
      .draw_if(draw_if)
   );

   assign head_v = {draw_if.op_o, draw_if.x1_o, draw_if.y1_o, draw_if.x2_o,
                    draw_if.y2_o, draw_if.rad_o, draw_if.r_o, draw_if.g_o, draw_if.b_o};

   task automatic check(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
   endtask

   function automatic logic [EW-1:0] mk(input logic [3:0] op, input logic [CB-1:0] rr,
                                        input logic [CB-1:0] gg, input logic [CB-1:0] bb);
      return {op, sx1, sy1, sx2, sy2, srad, rr, gg, bb};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_status(input string nm, input int cnt, input bit ovf);
      check({nm, "_count"}, EW'(count), EW'(cnt));
      check({nm, "_full"}, EW'(full), EW'(cnt == DEPTH));
      check({nm, "_empty"}, EW'(empty), EW'(cnt == 0));
      check({nm, "_overflow"}, EW'(overflow), EW'(ovf));
   endtask

   task automatic stage(input logic [3:0] op, input logic [WB-1:0] xv, input logic [HB-1:0] yv);
      opcode = op; write_enable = 1'b1;
      x1 = xv; x2 = xv; rad = xv; y1 = yv; y2 = yv;
      tick();
      write_enable = 1'b0;
      case (op)
         4'd1: begin sx1 = xv; sy1 = yv; end
         4'd2: begin sx2 = xv; sy2 = yv; end
         4'd3: srad = xv;
         default: ;
      endcase
   endtask

   task automatic push(input logic [3:0] op, input logic [CB-1:0] rr,
                       input logic [CB-1:0] gg, input logic [CB-1:0] bb);
      bit ok, full_b, pop_b, acc;
      logic [EW-1:0] e;
      ok     = (op == 4'd4) || (op == 4'd5);
      full_b = (exp_q.size() == DEPTH);
      pop_b  = draw_if.ready_i && (exp_q.size() != 0);
      acc    = ok && (!full_b || pop_b);
      e      = mk(op, rr, gg, bb);
      opcode = op; push_instruction = 1'b1; r = rr; g = gg; b = bb;
      tick();
      push_instruction = 1'b0;
      if (acc) exp_q.push_back(e);
      if (ok && !acc) ovf_m = 1'b1;
   endtask

   task automatic drain(input string nm);
      draw_if.ready_i = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      check({nm, "_drained"}, EW'(exp_q.size()), EW'(0));
      draw_if.ready_i = 1'b0;
   endtask

   // Monitor: compare the presented head against the scoreboard each cycle.
   always @(negedge clk) begin
      if (n_rst) begin
         check("valid", EW'(draw_if.valid_o), EW'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            check("head", head_v, exp_q[0]);
            if (draw_if.ready_i) void'(exp_q.pop_front());
         end else begin
            check("head_zero", head_v, EW'(0));
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   // Directed stimulus.
   initial begin
      command = 1'b0; opcode = 4'd0; x1 = '0; x2 = '0; rad = '0; y1 = '0; y2 = '0;
      r = '0; g = '0; b = '0; write_enable = 1'b0; push_instruction = 1'b0;
      draw_if.ready_i = 1'b0;
      sx1 = '0; sy1 = '0; sx2 = '0; sy2 = '0; srad = '0; ovf_m = 1'b0;

      // reset state
      #2 n_rst = 1'b0;
      #6;
      chk_status("reset", 0, 1'b0);
      check("reset_valid", EW'(draw_if.valid_o), EW'(0));
      check("reset_head", head_v, EW'(0));
      #4 n_rst = 1'b1;
      tick();

      // line with staged endpoints, held at head
      stage(4'd1, 10'd3, 9'd5);
      stage(4'd2, 10'd10, 9'd12);
      push(4'd4, 8'd1, 8'd2, 8'd3);
      chk_status("line", 1, 1'b0);
      check("line_op", EW'(draw_if.op_o), EW'(4'b0100));
      check("line_x1", EW'(draw_if.x1_o), EW'(3));
      check("line_y1", EW'(draw_if.y1_o), EW'(5));
      check("line_x2", EW'(draw_if.x2_o), EW'(10));
      check("line_y2", EW'(draw_if.y2_o), EW'(12));
      check("line_rgb", EW'({draw_if.r_o, draw_if.g_o, draw_if.b_o}), EW'(24'h010203));

      // radius staging, rect, ignored opcode 0110
      stage(4'd3, 10'd7, 9'd0);
      stage(4'd6, 10'd99, 9'd99);
      push(4'd5, 8'd4, 8'd5, 8'd6);
      push(4'd6, 8'd8, 8'd8, 8'd8);
      chk_status("ignored", 2, 1'b0);
      drain("first");
      push(4'd5, 8'd1, 8'd1, 8'd1);
      check("rect_rad", EW'(draw_if.rad_o), EW'(7));
      drain("rad");

      // overfill with rects
      stage(4'd1, 10'd20, 9'd30);
      for (int i = 0; i < DEPTH + 1; i++) push(4'd5, 8'(i), 8'(i + 1), 8'(i + 2));
      chk_status("overfill", 4, 1'b1);
      check("overfill_model_ovf", EW'(overflow), EW'(ovf_m));
      check("overfill_head_r", EW'(draw_if.r_o), EW'(0));

      // push and pop together while full
      draw_if.ready_i = 1'b1;
      push(4'd4, 8'd9, 8'd9, 8'd9);
      chk_status("full_pushpop", 4, 1'b1);
      check("full_pushpop_head_r", EW'(draw_if.r_o), EW'(1));
      drain("wrap");
      chk_status("wrap_after", 0, 1'b1);

      // soft clear with a simultaneous push strobe
      push(4'd4, 8'd2, 8'd2, 8'd2);
      push(4'd5, 8'd3, 8'd3, 8'd3);
      chk_status("pre_clear", 2, 1'b1);
      command = 1'b1; opcode = 4'd0; push_instruction = 1'b1;
      tick();
      command = 1'b0; push_instruction = 1'b0;
      exp_q.delete();
      sx1 = '0; sy1 = '0; sx2 = '0; sy2 = '0; srad = '0; ovf_m = 1'b0;
      chk_status("clear", 0, 1'b0);
      push(4'd4, 8'd7, 8'd7, 8'd7);
      check("clear_staging", EW'({draw_if.x1_o, draw_if.y1_o, draw_if.x2_o, draw_if.y2_o, draw_if.rad_o}), EW'(0));
      drain("clear");

      // asynchronous reset between edges with three queued entries
      stage(4'd1, 10'd1, 9'd2);
      push(4'd5, 8'd1, 8'd1, 8'd1);
      push(4'd5, 8'd2, 8'd2, 8'd2);
      push(4'd4, 8'd3, 8'd3, 8'd3);
      chk_status("pre_reset", 3, 1'b0);
      #2 n_rst = 1'b0;
      exp_q.delete();
      sx1 = '0; sy1 = '0; sx2 = '0; sy2 = '0; srad = '0; ovf_m = 1'b0;
      #1;
      chk_status("async_reset", 0, 1'b0);
      check("async_reset_valid", EW'(draw_if.valid_o), EW'(0));
      check("async_reset_head", head_v, EW'(0));
      #3 n_rst = 1'b1;
      check("release_empty", EW'(empty), EW'(1));
      push(4'd4, 8'd5, 8'd5, 8'd5);
      chk_status("first_push", 1, 1'b0);
      drain("final");

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
